// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: one active-low grant at a time, bus parking,
// hidden arbitration during transfers and an unused-grant timeout.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int PARK_MASTER = 0,
  parameter int PARK_EN     = 1,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_low,
  input  logic                 Frame,
  input  logic                 IRDY,
  input  logic [N_MASTERS-1:0] REQ_n,
  output logic [N_MASTERS-1:0] GNT_n,
  output logic [2:0]           bus_owner,
  output logic                 owner_valid,
  output logic                 gnt_timeout
);

  localparam int CW = $clog2(GNT_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(GNT_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ALL_HI = {N_MASTERS{1'b1}};
  localparam logic [N_MASTERS-1:0] PARK_GNT = (PARK_EN != 0) ?
      ~({{(N_MASTERS-1){1'b0}}, 1'b1} << PARK_MASTER) : {N_MASTERS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_GRANT = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [N_MASTERS-1:0]   gnt_n_r, gnt_n_s;
  logic [2:0]             owner_r, owner_s;
  logic                   owner_valid_r, owner_valid_s;
  logic                   timeout_r, timeout_s;
  logic [2:0]             last_r, last_s;
  logic [2:0]             win_r, win_s;
  logic [CW-1:0]          cnt_r, cnt_s;

  logic [2:0]             pick_s;
  logic [N_MASTERS-1:0]   pick_oh_s;
  logic [N_MASTERS-1:0]   win_oh_s;
  logic                   bus_idle_s;
  logic                   any_req_s;
  logic                   win_req_s;
  logic                   other_req_s;

  // Nearest requester after 'last', wrapping modulo N_MASTERS.
  function automatic logic [2:0] pick_winner(input logic [N_MASTERS-1:0] req_n,
                                             input logic [2:0] last);
    logic [2:0] best;
    int         best_d;
    int         d;
    best   = last;
    best_d = N_MASTERS;
    for (int j = 0; j < N_MASTERS; j++) begin
      d = (j + N_MASTERS - 1 - int'(last)) % N_MASTERS;
      if (!req_n[j] && (d < best_d)) begin
        best   = 3'(j);
        best_d = d;
      end else begin
        best_d = best_d;
      end
    end
    return best;
  endfunction

  function automatic logic [N_MASTERS-1:0] onehot(input logic [2:0] idx);
    logic [N_MASTERS-1:0] oh;
    for (int j = 0; j < N_MASTERS; j++) begin
      oh[j] = (3'(j) == idx);
    end
    return oh;
  endfunction

  // Request decoding against the current and the candidate winner.
  always_comb begin
    bus_idle_s  = Frame & IRDY;
    any_req_s   = ~&REQ_n;
    pick_s      = pick_winner(REQ_n, last_r);
    pick_oh_s   = onehot(pick_s);
    win_oh_s    = onehot(win_r);
    win_req_s   = |(~REQ_n & win_oh_s);
    other_req_s = |(~REQ_n & ~win_oh_s);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_s       = state_r;
    gnt_n_s       = gnt_n_r;
    owner_s       = owner_r;
    owner_valid_s = owner_valid_r;
    timeout_s     = 1'b0;
    last_s        = last_r;
    win_s         = win_r;
    cnt_s         = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (bus_idle_s && any_req_s) begin
          win_s = pick_s;
          cnt_s = '0;
          if (|(~gnt_n_r & pick_oh_s)) begin
            state_s = S_GRANT;
          end else if (~&gnt_n_r) begin
            gnt_n_s = ALL_HI;
            state_s = S_GAP;
          end else begin
            gnt_n_s = ~pick_oh_s;
            state_s = S_GRANT;
          end
        end else if (!any_req_s) begin
          gnt_n_s = PARK_GNT;
        end else begin
          gnt_n_s = gnt_n_r;
        end
      end
      S_GAP: begin
        if (any_req_s) begin
          win_s   = pick_s;
          gnt_n_s = ~pick_oh_s;
          cnt_s   = '0;
          state_s = S_GRANT;
        end else begin
          gnt_n_s = ALL_HI;
          state_s = S_IDLE;
        end
      end
      S_GRANT: begin
        // A started transaction takes precedence over a coincident timeout.
        if (!Frame) begin
          owner_s       = win_r;
          owner_valid_s = 1'b1;
          cnt_s         = '0;
          state_s       = S_BUSY;
        end else if (!win_req_s) begin
          gnt_n_s = ALL_HI;
          state_s = S_IDLE;
        end else if (cnt_r == TO_LAST) begin
          gnt_n_s   = ALL_HI;
          timeout_s = 1'b1;
          last_s    = win_r;
          state_s   = S_IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_BUSY: begin
        if (bus_idle_s) begin
          owner_valid_s = 1'b0;
          last_s        = win_r;
          if (win_req_s && !other_req_s) begin
            gnt_n_s = ~win_oh_s;
            cnt_s   = '0;
            state_s = S_GRANT;
          end else begin
            gnt_n_s = ALL_HI;
            state_s = S_IDLE;
          end
        end else if (other_req_s) begin
          gnt_n_s = ALL_HI;
        end else begin
          gnt_n_s = gnt_n_r;
        end
      end
      default: begin
        gnt_n_s       = ALL_HI;
        owner_valid_s = 1'b0;
        state_s       = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_r       <= S_IDLE;
      gnt_n_r       <= ALL_HI;
      owner_r       <= 3'd0;
      owner_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
      last_r        <= 3'(N_MASTERS - 1);
      win_r         <= 3'd0;
      cnt_r         <= '0;
    end else begin
      state_r       <= state_s;
      gnt_n_r       <= gnt_n_s;
      owner_r       <= owner_s;
      owner_valid_r <= owner_valid_s;
      timeout_r     <= timeout_s;
      last_r        <= last_s;
      win_r         <= win_s;
      cnt_r         <= cnt_s;
    end
  end

  assign GNT_n       = gnt_n_r;
  assign bus_owner   = owner_r;
  assign owner_valid = owner_valid_r;
  assign gnt_timeout = timeout_r;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (N_MASTERS=4, park on master 0, 16-cycle timeout).
module tb_pci_bus_arbiter;

  logic       clk;
  logic       reset_low;
  logic       Frame;
  logic       IRDY;
  logic [3:0] REQ_n;
  logic [3:0] GNT_n;
  logic [2:0] bus_owner;
  logic       owner_valid;
  logic       gnt_timeout;

  int n_chk = 0;
  int n_err = 0;
  int multi_err = 0;

  pci_bus_arbiter #(
    .N_MASTERS(4), .PARK_MASTER(0), .PARK_EN(1), .GNT_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_low(reset_low), .Frame(Frame), .IRDY(IRDY),
    .REQ_n(REQ_n), .GNT_n(GNT_n), .bus_owner(bus_owner),
    .owner_valid(owner_valid), .gnt_timeout(gnt_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count any cycle with more than one grant asserted.
  always @(negedge clk) begin
    if (reset_low === 1'b1 && $countones(~GNT_n) > 1) multi_err <= multi_err + 1;
    else multi_err <= multi_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (GNT_n === exp) break;
      tick();
    end
    chk(tag, 32'(GNT_n), 32'(exp));
  endtask

  initial begin
    int owners[5];
    int gaps[5];
    int nrec;
    int cur;
    int low_cnt;
    int phase;
    int hi_run;
    int to_cnt;
    int to_gnt;
    logic [3:0] exp_o;

    // 1: reset values, then park on master 0
    reset_low = 1'b1; Frame = 1'b1; IRDY = 1'b1; REQ_n = 4'b1111;
    #1 reset_low = 1'b0;
    #2;
    chk("rst_gnt", 32'(GNT_n), 32'(4'b1111));
    chk("rst_valid", 32'(owner_valid), 32'(1'b0));
    chk("rst_owner", 32'(bus_owner), 32'(3'd0));
    chk("rst_to", 32'(gnt_timeout), 32'(1'b0));
    #9 reset_low = 1'b1;
    tick();
    chk("park_gnt", 32'(GNT_n), 32'(4'b1110));
    chk("park_valid", 32'(owner_valid), 32'(1'b0));

    // 2: all masters request, one-phase transaction each
    REQ_n = 4'b0000;
    tick();
    nrec = 0; cur = -1; low_cnt = 0; phase = 0; hi_run = 0;
    for (int c = 0; c < 100 && nrec < 5; c++) begin
      if (GNT_n == 4'b1111) begin
        hi_run++; cur = -1; low_cnt = 0;
      end else begin
        for (int j = 0; j < 4; j++) begin
          if (!GNT_n[j] && j != cur) begin
            owners[nrec] = j; gaps[nrec] = hi_run; nrec++;
            cur = j; low_cnt = 0; phase = 0; hi_run = 0;
          end
        end
        low_cnt++;
      end
      if (nrec < 5) begin
        if (low_cnt == 2 && phase == 0) begin
          Frame = 1'b0; IRDY = 1'b0; phase = 1;
        end else if (phase == 1) begin
          Frame = 1'b1; IRDY = 1'b1; phase = 2;
        end
        tick();
      end
    end
    chk("rr_count", 32'(nrec), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_owner%0d", k), 32'(owners[k]), 32'(k % 4));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gaps[k]), 32'd1);
    end

    // 3: master 2 granted but never starts, grant withdrawn by timeout
    REQ_n = 4'b1111;
    tick(); tick();
    chk("park_again", 32'(GNT_n), 32'(4'b1110));
    REQ_n = 4'b1011;
    low_cnt = 0; to_cnt = 0; to_gnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (GNT_n == 4'b1011) low_cnt++;
      if (gnt_timeout) begin
        to_cnt++; to_gnt = 32'(GNT_n); REQ_n = 4'b1111;
      end
    end
    chk("to_low_cycles", 32'(low_cnt), 32'd16);
    chk("to_pulses", 32'(to_cnt), 32'd1);
    chk("to_gnt_high", 32'(to_gnt), 32'(4'b1111));
    chk("to_park", 32'(GNT_n), 32'(4'b1110));

    // 4: hidden arbitration while master 1 is busy
    REQ_n = 4'b1101;
    wait_gnt(4'b1101, "m1_gnt");
    Frame = 1'b0; IRDY = 1'b0;
    tick();
    chk("m1_busy_gnt", 32'(GNT_n), 32'(4'b1101));
    chk("m1_valid", 32'(owner_valid), 32'(1'b1));
    chk("m1_owner", 32'(bus_owner), 32'(3'd1));
    REQ_n = 4'b0101;
    tick();
    chk("hid_gnt_off", 32'(GNT_n), 32'(4'b1111));
    chk("hid_valid", 32'(owner_valid), 32'(1'b1));
    tick();
    chk("hid_valid2", 32'(owner_valid), 32'(1'b1));
    Frame = 1'b1; IRDY = 1'b1; REQ_n = 4'b0111;
    tick();
    chk("hid_gap", 32'(GNT_n), 32'(4'b1111));
    chk("hid_valid_off", 32'(owner_valid), 32'(1'b0));
    tick();
    chk("hid_m3_gnt", 32'(GNT_n), 32'(4'b0111));
    chk("hid_owner_kept", 32'(bus_owner), 32'(3'd1));
    REQ_n = 4'b1111;
    tick(); tick();

    // 5: master 0 alone, back-to-back transactions
    exp_o = 4'b1110;
    REQ_n = 4'b1110;
    tick();
    chk("b2b_gnt0", 32'(GNT_n), 32'(exp_o));
    for (int t = 0; t < 3; t++) begin
      Frame = 1'b0; IRDY = 1'b0;
      tick();
      chk($sformatf("b2b_busy_gnt%0d", t), 32'(GNT_n), 32'(exp_o));
      chk($sformatf("b2b_owner%0d", t), 32'(bus_owner), 32'(3'd0));
      chk($sformatf("b2b_valid%0d", t), 32'(owner_valid), 32'(1'b1));
      Frame = 1'b1; IRDY = 1'b1;
      tick();
      chk($sformatf("b2b_idle_gnt%0d", t), 32'(GNT_n), 32'(exp_o));
      chk($sformatf("b2b_idle_valid%0d", t), 32'(owner_valid), 32'(1'b0));
    end

    // 6: asynchronous reset in the middle of master 1's transaction
    REQ_n = 4'b1111;
    tick(); tick();
    REQ_n = 4'b1101;
    wait_gnt(4'b1101, "r6_gnt");
    Frame = 1'b0; IRDY = 1'b0;
    tick();
    chk("r6_valid", 32'(owner_valid), 32'(1'b1));
    #2 reset_low = 1'b0;
    #1;
    chk("r6_async_gnt", 32'(GNT_n), 32'(4'b1111));
    chk("r6_async_valid", 32'(owner_valid), 32'(1'b0));
    chk("r6_async_owner", 32'(bus_owner), 32'(3'd0));
    Frame = 1'b1; IRDY = 1'b1; REQ_n = 4'b1111;
    reset_low = 1'b1;
    tick();
    chk("r6_park", 32'(GNT_n), 32'(4'b1110));

    chk("single_grant", 32'(multi_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
